// File: rtl/xorseq_pkg.sv
// Shared definitions for the XOR vector sequencer: the FSM state encoding and
// the bit positions of the {valid, A, B, expected} fields in a ROM word.
package xorseq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        APPLY = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam int VLD = 3;
    localparam int A   = 2;
    localparam int B   = 1;
    localparam int EXP = 0;

endpackage

// File: rtl/xor_vector_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; it stops at all-ones and
// never wraps.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_q = cnt_q;

endmodule

// File: rtl/xor_vector_sequencer.sv
// Self-test sequencer for a 2-input XOR datapath: fetches vectors from a
// synchronous ROM, drives the DUT, checks its output and counts mismatches.
// Optional macro XORSEQ_STOP_ON_ERR_EN: stop at the first mismatch and report
// its address on o_fail_addr.
module xor_vector_sequencer
    import xorseq_pkg::*;
#(
    parameter int NUM_VECTORS = 8,
    parameter int ADDR_W      = 3,
    parameter int ERR_W       = 4
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_vec_rd,
    output logic [ADDR_W-1:0] o_vec_addr,
    input  logic [3:0]        i_vec_data,
    output logic              o_dut_a,
    output logic              o_dut_b,
    input  logic              i_dut_c,
    output logic [ADDR_W:0]   o_vec_count,
    output logic [ERR_W-1:0]  o_err_count,
    output logic              o_pass
`ifdef XORSEQ_STOP_ON_ERR_EN
    ,
    output logic [ADDR_W-1:0] o_fail_addr
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_VECTORS - 1);

    state_e            state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [ADDR_W:0]   vec_cnt_q, vec_cnt_d;
    logic              exp_q,     exp_d;
    logic              dut_a_q,   dut_a_d;
    logic              dut_b_q,   dut_b_d;
`ifdef XORSEQ_STOP_ON_ERR_EN
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
`endif
    logic              start_acc;
    logic              mismatch;
    logic              err_inc;

    assign start_acc = i_start && ((state_q == IDLE) || (state_q == DONE));
    // Case inequality: an X or Z from the DUT is a failure, not a pass.
    assign mismatch  = (i_dut_c !== exp_q);

    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        vec_cnt_d = vec_cnt_q;
        exp_d     = exp_q;
        dut_a_d   = dut_a_q;
        dut_b_d   = dut_b_q;
        err_inc   = 1'b0;
`ifdef XORSEQ_STOP_ON_ERR_EN
        fail_addr_d = fail_addr_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    addr_d    = '0;
                    vec_cnt_d = '0;
`ifdef XORSEQ_STOP_ON_ERR_EN
                    fail_addr_d = '0;
`endif
                    state_d   = FETCH;
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                if (!i_vec_data[VLD]) begin
                    state_d = DONE;
                end else begin
                    dut_a_d = i_vec_data[A];
                    dut_b_d = i_vec_data[B];
                    exp_d   = i_vec_data[EXP];
                    state_d = APPLY;
                end
            end
            APPLY: state_d = CHECK;
            CHECK: begin
                vec_cnt_d = vec_cnt_q + (ADDR_W + 1)'(1);
                err_inc   = mismatch;
                if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = FETCH;
                end
`ifdef XORSEQ_STOP_ON_ERR_EN
                if (mismatch) begin
                    addr_d      = addr_q;
                    fail_addr_d = addr_q;
                    state_d     = DONE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so each samples pre-edge values.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            vec_cnt_q <= '0;
            exp_q     <= 1'b0;
            dut_a_q   <= 1'b0;
            dut_b_q   <= 1'b0;
`ifdef XORSEQ_STOP_ON_ERR_EN
            fail_addr_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            vec_cnt_q <= vec_cnt_d;
            exp_q     <= exp_d;
            dut_a_q   <= dut_a_d;
            dut_b_q   <= dut_b_d;
`ifdef XORSEQ_STOP_ON_ERR_EN
            fail_addr_q <= fail_addr_d;
`endif
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_clr   (start_acc),
        .i_inc   (err_inc),
        .o_q     (o_err_count)
    );

    assign o_busy      = (state_q == FETCH) || (state_q == WAIT) ||
                         (state_q == APPLY) || (state_q == CHECK);
    assign o_done      = (state_q == DONE);
    assign o_vec_rd    = (state_q == FETCH);
    assign o_vec_addr  = addr_q;
    assign o_dut_a     = dut_a_q;
    assign o_dut_b     = dut_b_q;
    assign o_vec_count = vec_cnt_q;
    assign o_pass      = o_done && (o_err_count == '0);
`ifdef XORSEQ_STOP_ON_ERR_EN
    assign o_fail_addr = fail_addr_q;
`endif

endmodule

// File: tb/tb_xor_vector_sequencer.sv
// Bench for xor_vector_sequencer: table of ROM images and DUT models with
// hand-derived results, checked through a run-level scoreboard queue.
module tb_xor_vector_sequencer;

    localparam int NUM_VECTORS = 8;
    localparam int ADDR_W      = 3;
    localparam int ERR_W       = 2;
    localparam int MAX_CYCLES  = 200;
    localparam int M_XOR = 0, M_OR = 1, M_X = 2;

    typedef struct {
        string       name;
        logic [31:0] rom;   // entry i in bits [4*i +: 4]
        int          mode;
        int          cnt;
        int          err;
        int          pass;
        int          lat;   // edges from the start edge until o_done is seen
        int          a;
        int          b;
        int          rds;
        int          fail;
    } case_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy, done, vec_rd, dut_a, dut_b, dut_c, pass;
    logic [ADDR_W-1:0] vec_addr;
    logic [3:0]        vec_data;
    logic [ADDR_W:0]   vec_count;
    logic [ERR_W-1:0]  err_count;
`ifdef XORSEQ_STOP_ON_ERR_EN
    logic [ADDR_W-1:0] fail_addr;
`endif

    logic [31:0] rom_word = '0;
    logic [3:0]  rom_q    = '0;
    int          dut_mode = M_XOR;

    int n_checks = 0;
    int n_errors = 0;
    case_t tbl [8];
    case_t sb_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vec_rd) rom_q <= rom_word[4*vec_addr +: 4];
    end
    assign vec_data = rom_q;

    always_comb begin
        dut_c = 1'bx;
        case (dut_mode)
            M_XOR:   dut_c = dut_a ^ dut_b;
            M_OR:    dut_c = dut_a | dut_b;
            default: dut_c = 1'bx;
        endcase
    end

    xor_vector_sequencer #(
        .NUM_VECTORS (NUM_VECTORS),
        .ADDR_W      (ADDR_W),
        .ERR_W       (ERR_W)
    ) dut (
        .clk         (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .o_vec_rd    (vec_rd),
        .o_vec_addr  (vec_addr),
        .i_vec_data  (vec_data),
        .o_dut_a     (dut_a),
        .o_dut_b     (dut_b),
        .i_dut_c     (dut_c),
        .o_vec_count (vec_count),
        .o_err_count (err_count),
        .o_pass      (pass)
`ifdef XORSEQ_STOP_ON_ERR_EN
        ,
        .o_fail_addr (fail_addr)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic case_t mk(input string name, input logic [31:0] rom, input int mode,
                                 input int cnt, input int err, input int pass, input int lat,
                                 input int a, input int b, input int rds, input int fail);
        case_t c;
        c.name = name; c.rom = rom; c.mode = mode; c.cnt = cnt; c.err = err;
        c.pass = pass; c.lat = lat; c.a = a; c.b = b; c.rds = rds; c.fail = fail;
        return c;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy),      0);
        check({tag, "_done"},  32'(done),      0);
        check({tag, "_rd"},    32'(vec_rd),    0);
        check({tag, "_addr"},  32'(vec_addr),  0);
        check({tag, "_a"},     32'(dut_a),     0);
        check({tag, "_b"},     32'(dut_b),     0);
        check({tag, "_count"}, 32'(vec_count), 0);
        check({tag, "_err"},   32'(err_count), 0);
        check({tag, "_pass"},  32'(pass),      0);
`ifdef XORSEQ_STOP_ON_ERR_EN
        check({tag, "_fail_addr"}, 32'(fail_addr), 0);
`endif
    endtask

    task automatic pulse_start(input case_t c);
        rom_word = c.rom;
        dut_mode = c.mode;
        @(negedge clk);
        start = 1'b1;
        sb_q.push_back(c);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // poke >= 0 re-pulses i_start at that cycle of the run, which must be ignored.
    task automatic run_case(input case_t c, input int poke);
        case_t e;
        int    cycles = 0;
        int    exp_addr = 0;
        int    rds = 0;
        pulse_start(c);
        check({c.name, "_start_busy"},  32'(busy),      1);
        check({c.name, "_start_done"},  32'(done),      0);
        check({c.name, "_start_count"}, 32'(vec_count), 0);
        check({c.name, "_start_err"},   32'(err_count), 0);
        while (1) begin
            if (vec_rd) begin
                check({c.name, "_rd_addr"}, 32'(vec_addr), 32'(exp_addr));
                exp_addr++;
                rds++;
            end
            if (done || cycles >= MAX_CYCLES) break;
            start = (cycles == poke);
            @(posedge clk);
            #1 cycles++;
        end
        start = 1'b0;
        e = sb_q.pop_front();
        check({e.name, "_done_seen"}, 32'(done),      1);
        check({e.name, "_latency"},   32'(cycles),    32'(e.lat));
        check({e.name, "_reads"},     32'(rds),       32'(e.rds));
        check({e.name, "_count"},     32'(vec_count), 32'(e.cnt));
        check({e.name, "_err"},       32'(err_count), 32'(e.err));
        check({e.name, "_pass"},      32'(pass),      32'(e.pass));
        check({e.name, "_busy_low"},  32'(busy),      0);
        check({e.name, "_dut_a"},     32'(dut_a),     32'(e.a));
        check({e.name, "_dut_b"},     32'(dut_b),     32'(e.b));
`ifdef XORSEQ_STOP_ON_ERR_EN
        check({e.name, "_fail_addr"}, 32'(fail_addr), 32'(e.fail));
`endif
        repeat (3) @(posedge clk);
        #1 check({e.name, "_done_held"}, 32'(done), 1);
    endtask

    initial begin
        // Four vectors + marker: 4*4 cycles of vectors plus FETCH/WAIT for the marker.
`ifdef XORSEQ_STOP_ON_ERR_EN
        tbl[0] = mk("xor4",    32'h0000EDB8, M_XOR, 4, 0, 1, 18, 1, 1, 5, 0);
        tbl[1] = mk("or4",     32'h0000EDB8, M_OR,  4, 1, 0, 16, 1, 1, 4, 3);
        tbl[2] = mk("xor8",    32'hEDB8EDB8, M_XOR, 8, 0, 1, 32, 1, 1, 8, 0);
        tbl[3] = mk("x8",      32'hEDB8EDB8, M_X,   1, 1, 0,  4, 0, 0, 1, 0);
        tbl[4] = mk("or8",     32'hEDB8EDB8, M_OR,  4, 1, 0, 16, 1, 1, 4, 3);
        tbl[5] = mk("marker0", 32'h000EDB80, M_XOR, 0, 0, 1,  2, 1, 1, 1, 0);
        tbl[6] = mk("bad2",    32'h0008ECB8, M_XOR, 3, 1, 0, 12, 1, 0, 3, 2);
`else
        tbl[0] = mk("xor4",    32'h0000EDB8, M_XOR, 4, 0, 1, 18, 1, 1, 5, 0);
        tbl[1] = mk("or4",     32'h0000EDB8, M_OR,  4, 1, 0, 18, 1, 1, 5, 0);
        tbl[2] = mk("xor8",    32'hEDB8EDB8, M_XOR, 8, 0, 1, 32, 1, 1, 8, 0);
        tbl[3] = mk("x8",      32'hEDB8EDB8, M_X,   8, 3, 0, 32, 1, 1, 8, 0);
        tbl[4] = mk("or8",     32'hEDB8EDB8, M_OR,  8, 2, 0, 32, 1, 1, 8, 0);
        tbl[5] = mk("marker0", 32'h000EDB80, M_XOR, 0, 0, 1,  2, 1, 1, 1, 0);
        tbl[6] = mk("bad2",    32'h0008ECB8, M_XOR, 5, 1, 0, 22, 0, 0, 6, 0);
`endif
        tbl[7] = mk("poke",    32'h0000EDB8, M_XOR, 4, 0, 1, 18, 1, 1, 5, 0);

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_case(tbl[i], -1);
        end

        // Start pulse during CHECK of vector 1 (cycle 7 after the start edge).
        run_case(tbl[7], 7);

        // Reset asserted during APPLY of vector 1; outputs must clear without a clock edge.
        pulse_start(tbl[2]);
        repeat (6) @(posedge clk);
        #1 check("pre_reset_count", 32'(vec_count), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        void'(sb_q.pop_front());
        @(negedge clk) rst_n = 1'b1;
        run_case(tbl[0], -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
